// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding, iteration sizing
// and the field layout of the {remainder, quotient} result word.
package arith_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Two quotient bits retire per cycle, so a count of 1 still needs a 1-bit counter.
  function automatic int div_cnt_w(input int w);
    return (w / 2 > 1) ? $clog2(w / 2) : 1;
  endfunction

  localparam int DIV_ITER  = DIV_WIDTH / 2;
  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  localparam int QUO_LSB = 0;
  localparam int REM_LSB = DIV_WIDTH;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle for the iterative divider; the master issues
// operands, the slave (divider) returns {remainder, quotient}.
interface div_seq_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_signed;
  logic [WIDTH-1:0]   req_in_1;
  logic [WIDTH-1:0]   req_in_2;
  logic               resp_valid;
  logic [2*WIDTH-1:0] resp_result;

  modport master (
    output req_valid, req_signed, req_in_1, req_in_2,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_signed, req_in_1, req_in_2,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The restoring invariant keeps r_in < divisor, so shifted never needs bit WIDTH+1
  // and diff[WIDTH+1] is a clean borrow flag.
  always_comb begin
    shifted = {r_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    r_out   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_seq.sv
// Radix-4 iterative divider: two cascaded restoring steps per cycle on operand
// magnitudes, with sign and divide-by-zero fix-up in a final cycle.
//
// state | meaning
// IDLE  | ready for a request; operands captured on req_valid
// RUN   | two quotient bits per cycle, WIDTH/2 cycles
// FIX   | apply signs / divide-by-zero override, publish result
module div_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      reset,
  div_seq_if.slave bus
);

  localparam int ITER  = WIDTH / 2;
  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  div_state_e         state;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   raw;
  logic [WIDTH:0]     rem;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [2*WIDTH-1:0] resp_result_q;

  logic [WIDTH:0]     rem_mid;
  logic [WIDTH:0]     rem_nxt;
  logic               qb_hi;
  logic               qb_lo;

  logic               in1_neg;
  logic               in2_neg;
  logic [WIDTH-1:0]   abs_1;
  logic [WIDTH-1:0]   abs_2;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step_hi (
    .r_in    (rem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .r_out   (rem_mid),
    .q_bit   (qb_hi)
  );

  div_step #(.WIDTH(WIDTH)) u_step_lo (
    .r_in    (rem_mid),
    .bit_in  (dvd[WIDTH-2]),
    .divisor (dvs),
    .r_out   (rem_nxt),
    .q_bit   (qb_lo)
  );

  always_comb begin
    in1_neg = bus.req_signed & bus.req_in_1[WIDTH-1];
    in2_neg = bus.req_signed & bus.req_in_2[WIDTH-1];
    abs_1   = in1_neg ? -bus.req_in_1 : bus.req_in_1;
    abs_2   = in2_neg ? -bus.req_in_2 : bus.req_in_2;
  end

  // Divide-by-zero result is fixed regardless of signedness.
  always_comb begin
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (dz) begin
      quo_fix = '1;
      rem_fix = raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dvd           <= '0;
      dvs           <= '0;
      quo           <= '0;
      raw           <= '0;
      rem           <= '0;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz            <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state       <= RUN;
            req_ready_q <= 1'b0;
            dvd         <= abs_1;
            dvs         <= abs_2;
            rem         <= '0;
            quo         <= '0;
            neg_q       <= in1_neg ^ in2_neg;
            neg_r       <= in1_neg;
            dz          <= (bus.req_in_2 == '0);
            raw         <= bus.req_in_1;
            cnt         <= CNT_LAST;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-3:0], qb_hi, qb_lo};
          dvd <= {dvd[WIDTH-3:0], 2'b00};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          resp_result_q <= {rem_fix, quo_fix};
          resp_valid_q  <= 1'b1;
          req_ready_q   <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;

endmodule
